// File: rtl/dmem_responder_pkg.sv
// Shared CPU data-memory definitions: responder FSM encoding and default sizing.
package dmem_responder_pkg;

    localparam int DEF_DEPTH_WORDS = 256;
    localparam int DEF_LATENCY     = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM; read data is registered on enabled edges.
module dmem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clock,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [AW-1:0] i_idx,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (i_en) begin
            if (i_we) r_mem[i_idx] <= i_wdata;
            o_rdata <= r_mem[i_idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// CPU data-memory responder: accepts one request, waits LATENCY edges, then
// pulses a response carrying read data or an address error.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int LATENCY     = DEF_LATENCY
) (
    input  logic        clock,
    input  logic        reset_0,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall
);

    localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
    localparam logic [29:0] DEPTH_W  = 30'(DEPTH_WORDS);

    state_e      r_state, w_next;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr, r_wdata;
    logic        r_resp_valid, r_resp_err, r_resp_rd;
    logic        w_accept, w_done, w_err, w_mem_en;
    logic [31:0] w_mem_q;

    assign w_accept = req_valid && (r_state == IDLE);
    assign w_done   = (r_state == WAIT) && (r_cnt == 4'd0);
    assign w_err    = (|r_addr[1:0]) || (r_addr[31:2] >= DEPTH_W);
    // Gated by reset so an aborted write never reaches the array.
    assign w_mem_en = w_done && !w_err && !reset_0;

    always_ff @(posedge clock) begin
        if (reset_0) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_next = WAIT;
            WAIT:    if (r_cnt == 4'd0) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset_0) begin
            r_cnt        <= 4'd0;
            r_we         <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rd    <= 1'b0;
        end else begin
            r_resp_valid <= w_done;
            r_resp_err   <= w_done && w_err;
            r_resp_rd    <= w_done && !w_err && !r_we;
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_cnt   <= CNT_INIT;
            end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    dmem_array #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_array (
        .clock   (clock),
        .i_en    (w_mem_en),
        .i_we    (r_we),
        .i_idx   (r_addr[AW+1:2]),
        .i_wdata (r_wdata),
        .o_rdata (w_mem_q)
    );

    // Array output is the registered read; only exposed for a clean read response.
    assign resp_rdata = r_resp_rd ? w_mem_q : 32'd0;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign req_ready  = (r_state == IDLE);
    assign stall      = req_valid && !r_resp_valid;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, giving the number of 32-bit words of backing storage.
REQ-002 SHALL have parameter LATENCY, default 2, giving the number of clock edges from request acceptance to the response (legal range 1..15).
REQ-003 SHALL have one clock: clock input 1, with all state updated on its rising edge.
REQ-004 SHALL have reset reset_0 input 1, synchronous and active-high.
REQ-005 SHALL have req_valid input 1, CPU memory-stage request present.
REQ-006 SHALL have req_we input 1, 1 = write, 0 = read.
REQ-007 SHALL have req_addr input 32, byte address.
REQ-008 SHALL have req_wdata input 32, write data.
REQ-009 SHALL have req_ready output 1, high when the responder can accept a request.
REQ-010 SHALL have resp_valid output 1, a one-cycle pulse that completes the accepted request.
REQ-011 SHALL have resp_rdata output 32, read data, valid while resp_valid is high.
REQ-012 SHALL have resp_err output 1, request rejected, valid while resp_valid is high.
REQ-013 SHALL have stall output 1, combinational, used to freeze the CPU pipeline.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 SHALL drive req_ready = (state == IDLE).
REQ-016 SHALL accept a request on an edge where req_valid && req_ready is high, then:
- latch we, addr and wdata internally;
- load cnt with LATENCY-1;
- go to WAIT.
REQ-017 SHALL, in WAIT, decrement cnt each edge while cnt != 0, and go to RESP on the edge where cnt == 0.
REQ-018 SHALL, in RESP, hold resp_valid high for exactly one cycle, then return to IDLE on the next edge.
REQ-019 SHALL assert resp_valid during the cycle after edge E0+LATENCY, where E0 is the acceptance edge.
REQ-020 SHALL limit throughput to one request per LATENCY+2 cycles; there is no back-to-back acceptance.
REQ-021 SHALL drive stall = req_valid && !resp_valid, so the CPU advances exactly in the RESP cycle.
REQ-022 SHALL flag a latched address as an error when addr[1:0] != 0 or addr[31:2] >= DEPTH_WORDS.
REQ-023 SHALL, for an error request, suppress any write, drive resp_err = 1 and drive resp_rdata = 0.
REQ-024 SHALL commit a valid write on the edge that enters RESP, with resp_rdata = 0 for writes.
REQ-025 SHALL register the read result on the edge that enters RESP, using word index addr[31:2].
REQ-026 SHALL return the newly written word when a read follows a write to the same address.
REQ-027 SHALL sample request inputs only at acceptance; changes to them during WAIT or RESP have no effect.
REQ-028 SHALL ignore req_valid in WAIT and RESP, with no queueing.
REQ-029 SHALL hold resp_rdata and resp_err at 0 when resp_valid is 0.

Reset
REQ-030 SHALL, while reset_0 is high at an edge, set:
- state = IDLE, cnt = 0;
- resp_valid = 0, resp_rdata = 0, resp_err = 0;
- all latched request fields cleared.
REQ-031 SHALL abort an in-flight request on reset mid-operation: a pending write is never committed and no resp_valid is produced.
REQ-032 SHALL leave storage contents unchanged by reset.
REQ-033 SHALL have reset take priority over acceptance on the same edge.

Structure
REQ-034 SHALL place the FSM state encodings (IDLE=2'd0, WAIT=2'd1, RESP=2'd2), the default DEPTH_WORDS and the default LATENCY in the shared CPU package.
REQ-035 SHALL instantiate one sub-module, dmem_array: a single-port synchronous 32-bit RAM with write enable, addressed by word index.
REQ-036 SHALL keep the FSM, counter, error check and output registers in dmem_responder itself.

Verification
REQ-037 SHALL cover read after write, LATENCY=2: write addr 0x10 data 0xDEADBEEF, then read 0x10 -> second resp_valid arrives 2 edges after its acceptance, resp_rdata = 0xDEADBEEF, resp_err = 0.
REQ-038 SHALL cover a misaligned write: write addr 0x13 -> resp_err = 1; a later read of 0x10 returns its prior value unchanged.
REQ-039 SHALL cover out of range: read addr 4*DEPTH_WORDS (0x400 at default) -> resp_err = 1, resp_rdata = 0.
REQ-040 SHALL cover reset mid-operation: write 0x20 data 0x12345678, reset_0 high in the WAIT cycle -> no resp_valid; a later read of 0x20 returns its old value.
REQ-041 SHALL cover stall and handshake: req_valid held high for 3 consecutive requests -> stall is low only in RESP cycles, req_ready is low in WAIT/RESP, and exactly 3 resp_valid pulses spaced LATENCY+2 cycles apart.
REQ-042 SHALL cover LATENCY=1: read 0x0 -> resp_valid in the cycle after edge E0+1, and the FSM passes through WAIT for one edge.
